// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: Cartesian (re, im) -> phase (En30 rad) and
// gain-compensated magnitude (En15). One micro-rotation per clock.
module cordic_vec #(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned POINT_SZ   = 16,
  parameter int unsigned ANGLE_SZ   = 34,
  parameter int unsigned MAG_SZ     = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [POINT_SZ-1:0] i_re,
  input  logic [POINT_SZ-1:0] i_im,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [ANGLE_SZ-1:0] o_angle,
  output logic [MAG_SZ-1:0]   o_mag,
  output logic                o_valid,
  input  logic                i_ready
);

  // x/y carry 2 bits of headroom (fold + CORDIC gain) and 4 guard bits
  localparam int unsigned XY_W   = POINT_SZ + 6;
  localparam int unsigned IDX_W  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int unsigned PROD_W = XY_W + 17;
  localparam int unsigned RND_SH = 20;

  localparam logic signed [ANGLE_SZ-1:0] PI      = ANGLE_SZ'(64'd3373259426);
  localparam logic signed [PROD_W-1:0]   KINV    = PROD_W'(64'd39797);
  localparam logic signed [PROD_W-1:0]   RND     = PROD_W'(64'd1 << (RND_SH - 1));
  localparam logic signed [PROD_W-1:0]   MAG_MAX = PROD_W'((64'd1 << MAG_SZ) - 64'd1);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  // atan(2^-i) in En30, rounded to nearest
  function automatic logic signed [ANGLE_SZ-1:0] atan_lut(input logic [IDX_W-1:0] i);
    logic [31:0] v;
    case (i)
      IDX_W'(0):  v = 32'd843314857;
      IDX_W'(1):  v = 32'd497837829;
      IDX_W'(2):  v = 32'd263043837;
      IDX_W'(3):  v = 32'd133525159;
      IDX_W'(4):  v = 32'd67021687;
      IDX_W'(5):  v = 32'd33543516;
      IDX_W'(6):  v = 32'd16775851;
      IDX_W'(7):  v = 32'd8388437;
      IDX_W'(8):  v = 32'd4194283;
      IDX_W'(9):  v = 32'd2097149;
      IDX_W'(10): v = 32'd1048576;
      IDX_W'(11): v = 32'd524288;
      IDX_W'(12): v = 32'd262144;
      IDX_W'(13): v = 32'd131072;
      IDX_W'(14): v = 32'd65536;
      IDX_W'(15): v = 32'd32768;
      default:    v = 32'd0;
    endcase
    return ANGLE_SZ'(v);
  endfunction

  state_t                     state_q, state_d;
  logic signed [XY_W-1:0]     x_q, x_d, y_q, y_d;
  logic signed [ANGLE_SZ-1:0] z_q, z_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       zero_q, zero_d;
  logic                       o_ready_q, o_ready_d;
  logic                       o_valid_q, o_valid_d;
  logic [ANGLE_SZ-1:0]        o_angle_q, o_angle_d;
  logic [MAG_SZ-1:0]          o_mag_q, o_mag_d;

  logic signed [XY_W-1:0]     re_ext, im_ext, x_sh, y_sh;
  logic signed [PROD_W-1:0]   prod, mag_sh;

  // Datapath helpers: input scaling to En19, per-iteration shifts, gain compensation
  assign re_ext = XY_W'($signed(i_re)) <<< 4;
  assign im_ext = XY_W'($signed(i_im)) <<< 4;
  assign x_sh   = x_q >>> idx_q;
  assign y_sh   = y_q >>> idx_q;
  assign prod   = PROD_W'(x_q) * KINV + RND;
  assign mag_sh = prod >>> RND_SH;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    idx_d     = idx_q;
    zero_d    = zero_q;
    o_ready_d = o_ready_q;
    o_valid_d = o_valid_q;
    o_angle_d = o_angle_q;
    o_mag_d   = o_mag_q;
    case (state_q)
      IDLE: begin
        if (i_valid && o_ready_q) begin
          // Fold left half-plane into right half-plane so CORDIC converges
          if (i_re[POINT_SZ-1]) begin
            x_d = -re_ext;
            y_d = -im_ext;
            z_d = i_im[POINT_SZ-1] ? -PI : PI;
          end else begin
            x_d = re_ext;
            y_d = im_ext;
            z_d = '0;
          end
          zero_d    = (i_re == '0) && (i_im == '0);
          idx_d     = '0;
          o_ready_d = 1'b0;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (!y_q[XY_W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(idx_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(idx_q);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(ITERATIONS - 1)) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        if (zero_q) begin
          o_mag_d   = '0;
          o_angle_d = '0;
        end else begin
          o_angle_d = z_q;
          if (mag_sh[PROD_W-1]) begin
            o_mag_d = '0;
          end else if (mag_sh > MAG_MAX) begin
            o_mag_d = '1;
          end else begin
            o_mag_d = MAG_SZ'(mag_sh);
          end
        end
        o_valid_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (i_ready) begin
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      idx_q     <= '0;
      zero_q    <= 1'b0;
      o_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_angle_q <= '0;
      o_mag_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      idx_q     <= idx_d;
      zero_q    <= zero_d;
      o_ready_q <= o_ready_d;
      o_valid_q <= o_valid_d;
      o_angle_q <= o_angle_d;
      o_mag_q   <= o_mag_d;
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_angle = o_angle_q;
  assign o_mag   = o_mag_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Directed and random checks of the vectoring CORDIC: values, latency,
// handshake, backpressure and asynchronous reset.
module tb_cordic_vec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i_re = '0;
  logic [15:0] i_im = '0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_ready;
  logic [33:0] o_angle;
  logic [16:0] o_mag;
  logic        o_valid;

  int n_chk  = 0;
  int n_pass = 0;

  localparam real ANG_TOL = 65536.0;
  localparam real MAG_TOL = 3.0;
  localparam real SCALE30 = 1073741824.0;

  localparam logic [15:0] D_RE [6] = '{16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h8000, 16'h0000};
  localparam logic [15:0] D_IM [6] = '{16'h0000, 16'h4000, 16'hC000, 16'h0000, 16'h8000, 16'h0000};
  localparam real D_ANG [6] = '{0.0, 1686629713.0, -1686629713.0, 3373259426.0, -2529944570.0, 0.0};
  localparam real D_MAG [6] = '{16384.0, 16384.0, 16384.0, 16384.0, 46341.0, 0.0};
  localparam real D_AT  [6] = '{65536.0, 65536.0, 65536.0, 65536.0, 65536.0, 0.0};
  localparam real D_MT  [6] = '{3.0, 3.0, 3.0, 3.0, 3.0, 0.0};

  cordic_vec dut (
    .clk     (clk),
    .rst     (rst),
    .i_re    (i_re),
    .i_im    (i_im),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_angle (o_angle),
    .o_mag   (o_mag),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Present one sample, wait for acceptance and then for o_valid (bounded)
  task automatic run_sample(input logic [15:0] re, input logic [15:0] im,
                            output int waitn, output int lat,
                            output real ang, output real mag);
    waitn = 0;
    @(negedge clk);
    while (!o_ready && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    i_re = re;
    i_im = im;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ang = real'($signed(o_angle));
    mag = real'(o_mag);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #12;
    n_chk++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", o_ready); else n_pass++;
    n_chk++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_valid); else n_pass++;
    n_chk++;
    if (o_angle !== 34'd0) $display("FAIL reset_angle: got %0d want 0", o_angle); else n_pass++;
    n_chk++;
    if (o_mag !== 17'd0) $display("FAIL reset_mag: got %0d want 0", o_mag); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int  waitn, lat;
    real ang, mag;
    for (int i = 0; i < 6; i++) begin
      run_sample(D_RE[i], D_IM[i], waitn, lat, ang, mag);
      n_chk++;
      if (lat != 17) $display("FAIL dir%0d_latency: got %0d want 17", i, lat); else n_pass++;
      n_chk++;
      if (!(absr(ang - D_ANG[i]) <= D_AT[i]))
        $display("FAIL dir%0d_angle: got %0.0f want %0.0f", i, ang, D_ANG[i]);
      else n_pass++;
      n_chk++;
      if (!(absr(mag - D_MAG[i]) <= D_MT[i]))
        $display("FAIL dir%0d_mag: got %0.0f want %0.0f", i, mag, D_MAG[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic v_after;
    first = -1;
    second = -1;
    v_after = 1'b1;
    @(negedge clk);
    i_re = 16'h4000;
    i_im = 16'h0000;
    i_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (first >= 0 && c == first + 1) v_after = o_valid;
      if (o_valid) begin
        if (first < 0) first = c;
        else if (second < 0 && c > first + 1) second = c;
      end
    end
    n_chk++;
    if (v_after !== 1'b0) $display("FAIL b2b_pulse_width: o_valid after pulse got %0b want 0", v_after); else n_pass++;
    n_chk++;
    if (second - first != 19) $display("FAIL b2b_spacing: got %0d want 19", second - first); else n_pass++;
    @(negedge clk);
    i_valid = 1'b0;
    for (int c = 0; c < 40 && !o_ready; c++) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int  waitn, lat;
    real ang, mag, ang0, mag0;
    i_ready = 1'b0;
    run_sample(16'h6000, 16'h2000, waitn, lat, ang0, mag0);
    n_chk++;
    if (!(absr(ang0 - 345477027.0) <= ANG_TOL))
      $display("FAIL bp_angle: got %0.0f want 345477027", ang0);
    else n_pass++;
    n_chk++;
    if (!(absr(mag0 - 25905.0) <= MAG_TOL)) $display("FAIL bp_mag: got %0.0f want 25905", mag0); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      ang = real'($signed(o_angle));
      mag = real'(o_mag);
      n_chk++;
      if (o_valid !== 1'b1) $display("FAIL bp_hold_valid%0d: got %0b want 1", k, o_valid); else n_pass++;
      n_chk++;
      if (o_ready !== 1'b0) $display("FAIL bp_hold_ready%0d: got %0b want 0", k, o_ready); else n_pass++;
      n_chk++;
      if (ang != ang0) $display("FAIL bp_hold_angle%0d: got %0.0f want %0.0f", k, ang, ang0); else n_pass++;
      n_chk++;
      if (mag != mag0) $display("FAIL bp_hold_mag%0d: got %0.0f want %0.0f", k, mag, mag0); else n_pass++;
      if (k == 1) begin
        i_re = 16'hC000;
        i_im = 16'h0000;
        i_valid = 1'b1;
      end
      if (k == 2) i_valid = 1'b0;
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (o_valid !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", o_valid); else n_pass++;
    n_chk++;
    if (o_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", o_ready); else n_pass++;
    ang = real'($signed(o_angle));
    n_chk++;
    if (!(absr(ang - 345477027.0) <= ANG_TOL))
      $display("FAIL bp_release_angle_kept: got %0.0f want 345477027", ang);
    else n_pass++;
    run_sample(16'h6000, 16'hE000, waitn, lat, ang, mag);
    n_chk++;
    if (waitn != 0) $display("FAIL bp_next_accept_wait: got %0d want 0", waitn); else n_pass++;
    n_chk++;
    if (lat != 17) $display("FAIL bp_next_latency: got %0d want 17", lat); else n_pass++;
    n_chk++;
    if (!(absr(ang + 345477027.0) <= ANG_TOL))
      $display("FAIL bp_next_angle: got %0.0f want -345477027", ang);
    else n_pass++;
    n_chk++;
    if (!(absr(mag - 25905.0) <= MAG_TOL)) $display("FAIL bp_next_mag: got %0.0f want 25905", mag); else n_pass++;
  endtask

  task automatic test_random();
    int  waitn, lat;
    real ang, mag, re_r, im_r, exp_a, exp_m;
    logic [15:0] re, im;
    for (int n = 0; n < 1000; n++) begin
      re = 16'($urandom);
      im = 16'($urandom);
      run_sample(re, im, waitn, lat, ang, mag);
      re_r = real'($signed(re));
      im_r = real'($signed(im));
      exp_m = $sqrt(re_r * re_r + im_r * im_r);
      exp_a = $atan2(im_r, re_r) * SCALE30;
      n_chk++;
      if (!(absr(mag - exp_m) <= MAG_TOL))
        $display("FAIL rnd%0d_mag re=%0d im=%0d: got %0.0f want %0.2f", n, $signed(re), $signed(im), mag, exp_m);
      else n_pass++;
      if (exp_m >= 16384.0) begin
        n_chk++;
        if (!(absr(ang - exp_a) <= ANG_TOL))
          $display("FAIL rnd%0d_angle re=%0d im=%0d: got %0.0f want %0.0f", n, $signed(re), $signed(im), ang, exp_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int   waitn, lat;
    real  ang, mag;
    logic spur_valid, ready_lost;
    @(negedge clk);
    for (int c = 0; c < 40 && !o_ready; c++) @(negedge clk);
    i_re = 16'h8000;
    i_im = 16'h4000;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %0b want 0", o_valid); else n_pass++;
    n_chk++;
    if (o_ready !== 1'b1) $display("FAIL midrst_ready: got %0b want 1", o_ready); else n_pass++;
    n_chk++;
    if (o_angle !== 34'd0) $display("FAIL midrst_angle: got %0d want 0", o_angle); else n_pass++;
    n_chk++;
    if (o_mag !== 17'd0) $display("FAIL midrst_mag: got %0d want 0", o_mag); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spur_valid = 1'b0;
    ready_lost = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) spur_valid = 1'b1;
      if (!o_ready) ready_lost = 1'b1;
    end
    n_chk++;
    if (spur_valid !== 1'b0) $display("FAIL midrst_spurious_valid: got %0b want 0", spur_valid); else n_pass++;
    n_chk++;
    if (ready_lost !== 1'b0) $display("FAIL midrst_ready_held: ready dropped got %0b want 0", ready_lost); else n_pass++;
    run_sample(16'h4000, 16'h4000, waitn, lat, ang, mag);
    n_chk++;
    if (lat != 17) $display("FAIL midrst_next_latency: got %0d want 17", lat); else n_pass++;
    n_chk++;
    if (!(absr(ang - 843314857.0) <= ANG_TOL))
      $display("FAIL midrst_next_angle: got %0.0f want 843314857", ang);
    else n_pass++;
    n_chk++;
    if (!(absr(mag - 23170.0) <= MAG_TOL)) $display("FAIL midrst_next_mag: got %0.0f want 23170", mag); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
